// File: rtl/puf_arbiter_ctrl_pkg.sv
// puf_arbiter_ctrl_pkg: shared FSM state type, challenge width and parameter defaults
package puf_arbiter_ctrl_pkg;
  localparam int CHAL_W = 8;
  localparam int NUM_REPS_DEF = 15;
  localparam int SETTLE_CYC_DEF = 4;
  localparam int RACE_CYC_DEF = 4;
  typedef enum logic [2:0] {IDLE, SETUP, FIRE, SAMPLE, DONE} state_t;
endpackage

// File: rtl/puf_arbiter.sv
// puf_arbiter: race arbiter flop, samples the top path on the bottom path's rising edge
module puf_arbiter
  import puf_arbiter_ctrl_pkg::*;
(
  input  logic chain_top,
  input  logic chain_bot,
  input  logic arb_clr,
  output logic q
);
  (* DONT_TOUCH = "true" *) logic cap;
  // bottom edge is the arbiter clock; top already high means the top path won
  always_ff @(posedge chain_bot or posedge arb_clr)
    if (arb_clr) cap <= 1'b0;
    else cap <= chain_top;
  assign q = cap;
endmodule

// File: rtl/puf_arbiter_ctrl.sv
// puf_arbiter_ctrl: sequences repeated races through the arbiter chain and majority-votes the result
module puf_arbiter_ctrl
  import puf_arbiter_ctrl_pkg::*;
#(
  parameter int NUM_REPS = NUM_REPS_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int RACE_CYC = RACE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] challenge,
  output logic [CHAL_W-1:0] chal_out,
  output logic              launch,
  input  logic              chain_top,
  input  logic              chain_bot,
  output logic              busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              response,
  output logic [3:0]        ones_count
);
  state_t state, state_n;
  logic [7:0] phase_cnt;
  logic [3:0] rep_cnt;
  logic [3:0] ones_next;
  logic [1:0] sync;
  logic arb_clr, arb_q;
  logic race_on;
  puf_arbiter u_arb (
    .chain_top(chain_top),
    .chain_bot(chain_bot),
    .arb_clr(arb_clr),
    .q(arb_q)
  );
  assign busy = state != IDLE;
  // next-state logic; launch and arb_clr are registered from state_n so they never glitch
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SETUP;
      SETUP:   if (phase_cnt == 8'(SETTLE_CYC - 1)) state_n = FIRE;
      FIRE:    if (phase_cnt == 8'(RACE_CYC - 1)) state_n = SAMPLE;
      SAMPLE:  state_n = (rep_cnt < 4'(NUM_REPS - 1)) ? SETUP : DONE;
      DONE:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    race_on = (state_n == FIRE) || (state_n == SAMPLE);
    ones_next = (ones_count == 4'hF) ? 4'hF : ones_count + {3'b000, sync[1]};
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // datapath: phase timer, race counters, synchronizer and registered chain controls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase_cnt <= '0;
      rep_cnt <= '0;
      ones_count <= '0;
      chal_out <= '0;
      launch <= 1'b0;
      arb_clr <= 1'b1;
      sync <= '0;
      response <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      sync <= {sync[0], arb_q};
      launch <= race_on;
      arb_clr <= !race_on;
      resp_valid <= state_n == DONE;
      phase_cnt <= (state_n != state) ? 8'd0 : phase_cnt + 8'd1;
      if (state == IDLE && start) begin
        chal_out <= challenge;
        rep_cnt <= '0;
        ones_count <= '0;
        response <= 1'b0;
      end
      if (state == SAMPLE) begin
        ones_count <= ones_next;
        rep_cnt <= rep_cnt + 4'd1;
        if (state_n == DONE) response <= ones_next > 4'(NUM_REPS / 2);
      end
    end
endmodule
